// File: rtl/axis_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream packet arbiter.
// Default widths live here so the top-level parameter defaults and beat_t agree.
package axis_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_BUS_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int words_per_beat(input int bus_w, input int word_w);
        return bus_w / word_w;
    endfunction

    typedef logic [words_per_beat(DEF_BUS_W, DEF_WORD_W)-1:0][DEF_WORD_W-1:0] beat_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: returns the first asserted request at or after ptr,
// wrapping modulo N.
module rr_priority_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_idx = '0;
        any_req = |req;
        // Scan farthest-first so the request closest to ptr is the last (winning) assignment.
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (req[idx]) gnt_idx = IW'(idx);
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// N_S-to-1 AXI-Stream arbiter: round-robin grant locked for a whole packet,
// zero-latency data mux, only grant/pointer/beat counter are registered.
module axis_rr_packet_arbiter
    import axis_pkg::*;
#(
    parameter  int N_S       = 4,
    parameter  int WORD_W    = DEF_WORD_W,
    parameter  int BUS_W     = DEF_BUS_W,
    parameter  int MAX_BEATS = 256,
    localparam int WPB       = words_per_beat(BUS_W, WORD_W),
    localparam int DATA_W    = WPB * WORD_W,
    localparam int SEL_W     = $clog2(N_S),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_S-1:0]          s_valid,
    output logic [N_S-1:0]          s_ready,
    input  logic [N_S*DATA_W-1:0]   s_data,
    input  logic [N_S-1:0]          s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic [SEL_W-1:0]        m_sel,
    output logic [CNT_W-1:0]        m_beat
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             hs;

    rr_priority_pick #(.N(N_S)) u_pick (
        .req     (s_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        s_ready  = '0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_data   = s_data[int'(grant_q)*DATA_W +: DATA_W];
        hs       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_valid          = s_valid[grant_q];
                m_last           = s_last[grant_q];
                s_ready[grant_q] = m_ready;
                hs               = m_valid && m_ready;
                if (hs) begin
                    if (m_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == SEL_W'(N_S - 1)) ? '0 : grant_q + SEL_W'(1);
                        beat_d   = '0;
                    end else if (beat_q != CNT_W'(MAX_BEATS - 1)) begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_sel  = grant_q;
    assign m_beat = beat_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(s_ready));
    a_valid_busy:    assert property (@(posedge clk) disable iff (rst) m_valid |-> (state_q == BUSY));
    a_data_stable:   assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY && s_valid[grant_q] && !s_ready[grant_q]) |=> $stable(m_data));
    a_beat_overflow: assert property (@(posedge clk) disable iff (rst)
        !(hs && !m_last && beat_q == CNT_W'(MAX_BEATS - 1)));

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Scoreboard bench for axis_rr_packet_arbiter: per-source expected beat queues,
// an expected grant-order queue, and a monitor that checks every handshake.
module tb_axis_rr_packet_arbiter;

    localparam int N_S    = 4;
    localparam int WORD_W = 8;
    localparam int BUS_W  = 32;
    localparam int MAXB   = 256;
    localparam int DW     = 32;
    localparam int SW     = 2;
    localparam int CW     = 9;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } tx_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_S-1:0]    s_valid;
    logic [N_S-1:0]    s_ready;
    logic [N_S*DW-1:0] s_data;
    logic [N_S-1:0]    s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [SW-1:0]     m_sel;
    logic [CW-1:0]     m_beat;

    tx_t  tx_q  [N_S][$];
    exp_t exp_q [N_S][$];
    int   exp_sel_q[$];
    int   prob_v [N_S];
    int   prob_r;
    bit   check_gap;
    bit   gap_prev;
    int   n_cmp  = 0;
    int   n_fail = 0;

    axis_rr_packet_arbiter #(
        .N_S(N_S), .WORD_W(WORD_W), .BUS_W(BUS_W), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_sel(m_sel), .m_beat(m_beat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic send_pkt(input int src, input int nbeats, input logic [7:0] tag, input bit rnd);
        for (int b = 0; b < nbeats; b++) begin
            tx_t  t;
            exp_t e;
            t.data = rnd ? DW'($urandom) : {8'(src), tag, 8'(b), 8'h5A};
            t.last = (b == nbeats - 1);
            e.data = t.data;
            e.last = t.last;
            e.idx  = b;
            tx_q[src].push_back(t);
            exp_q[src].push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int pending;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            pending = 0;
            for (int i = 0; i < N_S; i++) pending += exp_q[i].size();
            if (pending == 0) break;
        end
        pending = 0;
        for (int i = 0; i < N_S; i++) pending += exp_q[i].size();
        check(name, pending, 0);
        repeat (2) @(negedge clk);
    endtask

    // Source and sink models: valid/ready raised at random, held until handshake.
    initial begin : drivers
        bit hs [N_S];
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_S; i++) hs[i] = !rst && s_valid[i] && s_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N_S; i++) begin
                if (hs[i]) begin
                    if (tx_q[i].size() > 0) void'(tx_q[i].pop_front());
                    s_valid[i] = 1'b0;
                end
                if (!s_valid[i] && tx_q[i].size() > 0 && $urandom_range(99, 0) < prob_v[i]) begin
                    s_valid[i]         = 1'b1;
                    s_data[i*DW +: DW] = tx_q[i][0].data;
                    s_last[i]          = tx_q[i][0].last;
                end
            end
            m_ready = ($urandom_range(99, 0) < prob_r);
        end
    end

    initial begin : monitor
        bit   in_pkt = 1'b0;
        int   cur_sel = 0;
        int   since_last = 1000;
        int   waitc [N_S];
        exp_t e;
        for (int i = 0; i < N_S; i++) waitc[i] = 0;
        forever begin
            @(negedge clk);
            if (since_last < 1000) since_last++;
            if (rst) begin
                in_pkt = 1'b0;
                for (int i = 0; i < N_S; i++) waitc[i] = 0;
            end else begin
                if (m_valid && !in_pkt) begin
                    in_pkt  = 1'b1;
                    cur_sel = int'(m_sel);
                    if (check_gap && gap_prev) check("bubble_gap", since_last, 2);
                    if (exp_sel_q.size() > 0) check("grant_order", m_sel, exp_sel_q.pop_front());
                    check("fair_wait_over_3", waitc[m_sel] > 3, 0);
                    waitc[m_sel] = 0;
                end
                if (m_valid && m_ready) begin
                    check("no_interleave", m_sel, cur_sel);
                    if (exp_q[m_sel].size() == 0) begin
                        check("unexpected_beat_src", m_sel, N_S);
                    end else begin
                        e = exp_q[m_sel].pop_front();
                        check("m_data", m_data, e.data);
                        check("m_last", m_last, e.last);
                        check("m_beat", m_beat, e.idx);
                    end
                    if (m_last) begin
                        in_pkt     = 1'b0;
                        since_last = 0;
                        gap_prev   = 1'b1;
                        for (int j = 0; j < N_S; j++)
                            if (j != int'(m_sel) && s_valid[j]) waitc[j]++;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        rst       = 1'b1;
        s_valid   = '0;
        s_data    = '0;
        s_last    = '0;
        m_ready   = 1'b0;
        prob_r    = 100;
        check_gap = 1'b0;
        gap_prev  = 1'b0;
        for (int i = 0; i < N_S; i++) prob_v[i] = 100;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_sel", m_sel, 0);
        check("rst_m_beat", m_beat, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // All four sources, 3-beat packets together: order 0,1,2,3 with one bubble each.
        @(negedge clk);
        check_gap = 1'b1;
        gap_prev  = 1'b0;
        for (int s = 0; s < N_S; s++) begin
            send_pkt(s, 3, 8'h10 + 8'(s), 1'b0);
            exp_sel_q.push_back(s);
        end
        wait_drain("drain_t1", 500);

        // src2 alone, two back-to-back packets: bubble between them, rr_ptr ends at 3.
        gap_prev = 1'b0;
        send_pkt(2, 2, 8'h20, 1'b0);
        send_pkt(2, 2, 8'h21, 1'b0);
        exp_sel_q.push_back(2);
        exp_sel_q.push_back(2);
        wait_drain("drain_t2", 500);

        // rr_ptr=3 with src3 idle: src0 wins by wrap, then src1.
        gap_prev = 1'b0;
        send_pkt(0, 2, 8'h40, 1'b0);
        send_pkt(1, 2, 8'h41, 1'b0);
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(1);
        wait_drain("drain_t4", 500);

        // src1 10-beat packet at 30% valid/ready; src0/src3 join mid-packet and must wait.
        check_gap = 1'b0;
        prob_v[1] = 30;
        prob_r    = 30;
        send_pkt(1, 10, 8'h30, 1'b0);
        exp_sel_q.push_back(1);
        exp_sel_q.push_back(3);
        exp_sel_q.push_back(0);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (m_valid && m_sel == 2'd1) found = 1'b1;
        end
        check("t3_src1_started", found, 1);
        send_pkt(0, 2, 8'h31, 1'b0);
        send_pkt(3, 2, 8'h32, 1'b0);
        wait_drain("drain_t3", 3000);
        prob_v[1] = 100;
        prob_r    = 100;

        // Reset while beat 4 of an 8-beat src2 packet is presented.
        send_pkt(2, 8, 8'h50, 1'b0);
        exp_sel_q.push_back(2);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_sel == 2'd2 && m_beat == CW'(3)) found = 1'b1;
        end
        check("t5_beat3_seen", found, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tx_q[2].delete();
        exp_q[2].delete();
        s_valid[2] = 1'b0;
        s_last[2]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_s_ready", s_ready, 0);
        check("t5_m_valid", m_valid, 0);
        check("t5_m_sel", m_sel, 0);
        check("t5_m_beat", m_beat, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        check_gap = 1'b1;
        gap_prev  = 1'b0;
        send_pkt(0, 3, 8'h60, 1'b0);
        send_pkt(3, 3, 8'h61, 1'b0);
        exp_sel_q.push_back(0);
        exp_sel_q.push_back(3);
        wait_drain("drain_t5", 500);
        check("t5_order_consumed", exp_sel_q.size(), 0);

        // Random traffic: 200 packets, 1..16 beats, 20..100% valid/ready.
        check_gap = 1'b0;
        for (int i = 0; i < N_S; i++) prob_v[i] = $urandom_range(100, 20);
        prob_r = $urandom_range(100, 20);
        for (int k = 0; k < 200; k++)
            send_pkt($urandom_range(N_S - 1, 0), $urandom_range(16, 1), 8'(k), 1'b1);
        wait_drain("drain_random", 40000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
